// File: rtl/read_page_sequencer.sv
// read_page_sequencer: NAND page-read sequencer with bad-block check and ECC tally.
// Optional ready/busy timeout is built when READ_TIMEOUT_EN is defined.
module read_page_sequencer #(
    parameter int RB_TIMEOUT = 50000,
    parameter int TWB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] page_row,
    input  logic        flash_rb,
    input  logic [1:0]  addr_row_error,
    input  logic        ecc_success,
    input  logic [1:0]  ecc_state,
    output logic [4:0]  state,
    output logic [23:0] addr_row,
    output logic        en_read,
    output logic        tRead,
    output logic [13:0] read_data_cnt,
    output logic        busy,
    output logic        done,
    output logic [1:0]  page_status,
    output logic [6:0]  corr_cnt
);

    typedef enum logic [4:0] {
        S_IDLE      = 5'd0,
        S_BADCHK    = 5'd1,
        S_CMD_START = 5'd2,
        S_ADDR      = 5'd3,
        S_CMD_FIN   = 5'd4,
        S_WAIT_RB   = 5'd5,
        S_DATA      = 5'd10,
        S_ECC       = 5'd18,
        S_DONE      = 5'd19,
        S_ERR       = 5'd20
    } state_t;

    localparam logic [13:0] LAST_BYTE = 14'd8383;
    localparam logic [7:0]  TWB_LIM   = 8'(TWB_CYCLES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_addr_cyc;
    logic [7:0]  r_twb_cnt;
    logic [1:0]  r_rb_sync;
    logic        r_tread;
    logic [13:0] r_cnt;
    logic [23:0] r_addr_row;
    logic [1:0]  r_status;
    logic [6:0]  r_corr;
    logic        w_twb_done;
    logic        w_rb_ready;
    logic        w_last;
    logic        w_timeout;

    assign w_twb_done = (r_twb_cnt == TWB_LIM);
    assign w_rb_ready = r_rb_sync[1];
    assign w_last     = r_tread && (r_cnt == LAST_BYTE);

`ifdef READ_TIMEOUT_EN
    localparam logic [16:0] TO_LIM = 17'(RB_TIMEOUT - 1);
    logic [16:0] r_to_cnt;

    assign w_timeout = w_twb_done && !w_rb_ready && (r_to_cnt == TO_LIM);

    // Counts ready/busy wait cycles once tWB has elapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT_RB) begin
            r_to_cnt <= '0;
        end else if (w_twb_done && !w_rb_ready) begin
            r_to_cnt <= r_to_cnt + 17'd1;
        end
    end
`else
    // Without the timeout the ready/busy wait never gives up
    assign w_timeout = (RB_TIMEOUT < 0);
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_BADCHK;
            S_BADCHK: begin
                if (addr_row_error == 2'd1) begin
                    w_state_nxt = S_CMD_START;
                end else if (addr_row_error[1]) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_CMD_START: w_state_nxt = S_ADDR;
            S_ADDR:      if (r_addr_cyc == 3'd4) w_state_nxt = S_CMD_FIN;
            S_CMD_FIN:   w_state_nxt = S_WAIT_RB;
            S_WAIT_RB: begin
                if (w_twb_done && w_rb_ready) begin
                    w_state_nxt = S_DATA;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DATA:      if (w_last) w_state_nxt = S_ECC;
            S_ECC:       if (ecc_success) w_state_nxt = S_DONE;
            S_DONE:      w_state_nxt = S_IDLE;
            S_ERR:       w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: address latch, phase counters, byte counter, ECC tally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rb_sync  <= '0;
            r_addr_cyc <= '0;
            r_twb_cnt  <= '0;
            r_tread    <= 1'b0;
            r_cnt      <= '0;
            r_addr_row <= '0;
            r_status   <= '0;
            r_corr     <= '0;
        end else begin
            r_rb_sync <= {r_rb_sync[0], flash_rb};
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr_row <= page_row;
                        r_corr     <= '0;
                        r_status   <= '0;
                    end
                end
                S_BADCHK: begin
                    if (addr_row_error[1]) r_status <= 2'd3;
                end
                S_ADDR: begin
                    r_addr_cyc <= (r_addr_cyc == 3'd4) ? 3'd0 : r_addr_cyc + 3'd1;
                end
                S_CMD_FIN: begin
                    r_twb_cnt <= '0;
                end
                S_WAIT_RB: begin
                    if (!w_twb_done) r_twb_cnt <= r_twb_cnt + 8'd1;
                    if (w_timeout) r_status <= 2'd3;
                    if (w_twb_done && w_rb_ready) begin
                        r_cnt   <= '0;
                        r_tread <= 1'b0;
                    end
                end
                S_DATA: begin
                    r_tread <= !r_tread;
                    if (r_tread && !w_last) r_cnt <= r_cnt + 14'd1;
                end
                S_ECC: begin
                    if (ecc_state == 2'd2) begin
                        if (r_corr != 7'd127) r_corr <= r_corr + 7'd1;
                        if (r_status == 2'd0) r_status <= 2'd1;
                    end else if (ecc_state == 2'd3) begin
                        r_status <= 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state         = r_state;
    assign addr_row      = r_addr_row;
    assign tRead         = r_tread;
    assign read_data_cnt = r_cnt;
    assign page_status   = r_status;
    assign corr_cnt      = r_corr;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE) || (r_state == S_ERR);
    assign en_read       = busy && !done;

endmodule

// File: tb/tb_read_page_sequencer.sv
// tb_read_page_sequencer: directed pages checked against a page-level model.
// Timeout scenario is included when READ_TIMEOUT_EN is defined.
module tb_read_page_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] page_row = '0;
    logic        flash_rb = 1'b0;
    logic [1:0]  addr_row_error = '0;
    logic        ecc_success = 1'b0;
    logic [1:0]  ecc_state = '0;
    logic [4:0]  state;
    logic [23:0] addr_row;
    logic        en_read;
    logic        tRead;
    logic [13:0] read_data_cnt;
    logic        busy;
    logic        done;
    logic [1:0]  page_status;
    logic [6:0]  corr_cnt;

    read_page_sequencer #(.RB_TIMEOUT(100), .TWB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .page_row(page_row),
        .flash_rb(flash_rb), .addr_row_error(addr_row_error),
        .ecc_success(ecc_success), .ecc_state(ecc_state),
        .state(state), .addr_row(addr_row), .en_read(en_read),
        .tRead(tRead), .read_data_cnt(read_data_cnt), .busy(busy),
        .done(done), .page_status(page_status), .corr_cnt(corr_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] m_row = '0;
    int          n_rise = 0;
    int          prev_st = 0;
    int          run_len = 0;
    int          data_i = 0;
    bit          prev_tr = 0;
    bit          prev13 = 0;
    int          q_st[$];
    int          q_len[$];
    int          e_st[$];
    int          e_len[$];
    logic [1:0]  ecc_v[64];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic set_ecc(input logic [1:0] fill);
        for (int k = 0; k < 64; k++) ecc_v[k] = fill;
    endtask

    task automatic add_exp(input int s, input int l);
        e_st.push_back(s);
        e_len.push_back(l);
    endtask

    task automatic exp_good();
        e_st.delete();
        e_len.delete();
        add_exp(1, -1); add_exp(2, 1); add_exp(3, 5); add_exp(4, 1);
        add_exp(5, -1); add_exp(10, 2 * 8384); add_exp(18, 64);
        add_exp(19, 1);
    endtask

    // Page outcome from the chunk verdicts alone
    task automatic exp_result(input bit fail, output logic [1:0] st,
                              output logic [6:0] cc);
        int  n2;
        bit  any3;
        n2 = 0;
        any3 = 0;
        for (int k = 0; k < 64; k++) begin
            if (ecc_v[k] == 2'd2) n2++;
            if (ecc_v[k] == 2'd3) any3 = 1;
        end
        if (fail) begin
            st = 2'd3;
            cc = 7'd0;
        end else begin
            st = any3 ? 2'd2 : (n2 > 0 ? 2'd1 : 2'd0);
            cc = (n2 > 127) ? 7'd127 : 7'(n2);
        end
    endtask

    // Every-cycle comparison against the page-level model
    always @(negedge clk) begin
        int st;
        if (rst) begin
            prev_st = 0;
            run_len = 0;
            prev_tr = 0;
            prev13 = 0;
            data_i = 0;
        end else begin
            st = int'(state);
            chk("en_read", en_read, (st >= 1 && st <= 5) || st == 10 || st == 18);
            chk("busy", busy, st != 0);
            chk("done", done, st == 19 || st == 20);
            if (st == 10) begin
                chk("data_cnt", read_data_cnt, data_i / 2);
                chk("data_tRead", tRead, data_i % 2);
                data_i++;
            end else begin
                chk("tRead_off", tRead, 0);
                data_i = 0;
            end
            if (st == 18) chk("ecc_cnt_hold", read_data_cnt, 8383);
            if (st != 0) chk("addr_row", addr_row, m_row);
            if (tRead && !prev_tr) n_rise++;
            if (read_data_cnt[13] && !prev13)
                chk("cnt13_rise", read_data_cnt, 8192);
            if (st != prev_st) begin
                if (prev_st != 0) begin
                    q_st.push_back(prev_st);
                    q_len.push_back(run_len);
                end
                prev_st = st;
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_tr = tRead;
            prev13 = read_data_cnt[13];
        end
    end

    task automatic chk_reset();
        chk("rst_state", state, 0);
        chk("rst_cnt", read_data_cnt, 0);
        chk("rst_en_read", en_read, 0);
        chk("rst_tRead", tRead, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr_row", addr_row, 0);
        chk("rst_status", page_status, 0);
        chk("rst_corr", corr_cnt, 0);
    endtask

    task automatic do_page(input logic [23:0] row, input logic [1:0] verdict,
                           input bit poke, input int rst_at,
                           input bit rb_never);
        int         cyc;
        bit         seen;
        logic [1:0] es;
        logic [6:0] ec;
        q_st.delete();
        q_len.delete();
        n_rise = 0;
        addr_row_error = 2'd0;
        flash_rb = 1'b0;
        ecc_state = 2'd0;
        ecc_success = 1'b0;
        @(negedge clk);
        start = 1'b1;
        page_row = row;
        m_row = row;
        @(negedge clk);
        start = 1'b0;
        page_row = 24'hABCDEF;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 40000) begin
            if (cyc == 2) addr_row_error = verdict;
            if (cyc == 20 && !rb_never) flash_rb = 1'b1;
            if (poke && state == 5'd10 && read_data_cnt == 14'd100 && !tRead) begin
                start = 1'b1;
                page_row = 24'h5A5A5A;
            end else begin
                start = 1'b0;
            end
            if (rst_at >= 0 && state == 5'd10 && read_data_cnt == 14'(rst_at)) begin
                #2 rst = 1'b1;
                #1 chk_reset();
                @(negedge clk);
                #2 rst = 1'b0;
                return;
            end
            if (state == 5'd18) begin
                for (int k = 0; k < 64; k++) begin
                    ecc_state = ecc_v[k];
                    ecc_success = (k == 63);
                    @(negedge clk);
                end
                ecc_state = 2'd0;
                ecc_success = 1'b0;
            end
            if (done) begin
                seen = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", seen, 1);
        if (poke) chk("addr_row_kept", addr_row, row);
        exp_result(verdict != 2'd1 || rb_never, es, ec);
        chk("page_status", page_status, es);
        chk("corr_cnt", corr_cnt, ec);
        @(negedge clk);
        #1;
        chk("back_idle", state, 0);
        chk("status_held", page_status, es);
        chk("corr_held", corr_cnt, ec);
        chk("tread_rises", n_rise, (verdict == 2'd1 && !rb_never) ? 8384 : 0);
        chk("seq_count", q_st.size(), e_st.size());
        for (int i = 0; i < e_st.size(); i++) begin
            if (i < q_st.size()) begin
                chk("seq_state", q_st[i], e_st[i]);
                if (e_len[i] >= 0) chk("seq_len", q_len[i], e_len[i]);
            end
        end
        addr_row_error = 2'd0;
        flash_rb = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk_reset();
        @(negedge clk);
        rst = 1'b0;

        // Clean page
        set_ecc(2'd1);
        exp_good();
        do_page(24'h000080, 2'd1, 0, -1, 0);
        chk("pin_good_status", page_status, 0);
        chk("pin_good_corr", corr_cnt, 0);
        chk("pin_good_row", addr_row, 24'h000080);

        // Bad block
        e_st.delete();
        e_len.delete();
        add_exp(1, -1);
        add_exp(20, 1);
        do_page(24'h123456, 2'd2, 0, -1, 0);
        chk("pin_bad_status", page_status, 3);

        // ECC accumulation, start poked during DATA, verdict with success
        set_ecc(2'd1);
        ecc_v[5] = 2'd2;
        ecc_v[17] = 2'd2;
        ecc_v[40] = 2'd3;
        ecc_v[63] = 2'd2;
        exp_good();
        do_page(24'h00C0DE, 2'd1, 1, -1, 0);
        chk("pin_acc_status", page_status, 2);
        chk("pin_acc_corr", corr_cnt, 3);

        // Reset mid-page, then a normal page
        set_ecc(2'd1);
        do_page(24'h0000AA, 2'd1, 0, 4000, 0);
        ecc_v[9] = 2'd2;
        exp_good();
        do_page(24'h00BEEF, 2'd1, 0, -1, 0);
        chk("pin_after_rst_status", page_status, 1);
        chk("pin_after_rst_corr", corr_cnt, 1);

`ifdef READ_TIMEOUT_EN
        // Ready/busy never returns
        e_st.delete();
        e_len.delete();
        add_exp(1, -1); add_exp(2, 1); add_exp(3, 5); add_exp(4, 1);
        add_exp(5, -1); add_exp(20, 1);
        do_page(24'h000777, 2'd1, 0, -1, 1);
        chk("pin_to_status", page_status, 3);
        if (q_len.size() > 4)
            chk("to_wait_len", (q_len[4] >= 100 && q_len[4] <= 110), 1);
        else
            chk("to_wait_seen", q_len.size(), 6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/read_page_sequencer.md
READ_PAGE_SEQUENCER -- requirements
Module: read_page_sequencer

Interface
REQ-001 SHALL have parameter RB_TIMEOUT, default 50000, meaning the cycle limit for the ready/busy wait (used only with READ_TIMEOUT_EN).
REQ-002 SHALL have parameter TWB_CYCLES, default 4, meaning the cycles waited after the final command before flash_rb is sampled.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, one-cycle page-read request.
REQ-006 SHALL have port page_row, input, 24, row address, latched on an accepted start.
REQ-007 SHALL have port flash_rb, input, 1, flash ready/busy (1 = ready), asynchronous to clk.
REQ-008 SHALL have port addr_row_error, input, 2, bad-block verdict: 0 pending, 1 good, 2 bad.
REQ-009 SHALL have port ecc_success, input, 1, one-cycle pulse at the end of the ECC compare.
REQ-010 SHALL have port ecc_state, input, 2, per-chunk ECC verdict: 1 ok, 2 corrected, 3 uncorrectable.
REQ-011 SHALL have port state, output, 5, sequencer state code.
REQ-012 SHALL have port addr_row, output, 24, the latched row address.
REQ-013 SHALL have port en_read, output, 1, read-path enable.
REQ-014 SHALL have port tRead, output, 1, read-strobe phase.
REQ-015 SHALL have port read_data_cnt, output, 14, byte counter for the data phase.
REQ-016 SHALL have port busy, output, 1, high while a page read is in progress.
REQ-017 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-018 SHALL have port page_status, output, 2, result: 0 clean, 1 corrected, 2 uncorrectable, 3 bad block or timeout.
REQ-019 SHALL have port corr_cnt, output, 7, number of chunks reported as corrected.

Function
REQ-020 SHALL use these state codes: IDLE=0, BADCHK=1, CMD_START=2, ADDR=3, CMD_FIN=4, WAIT_RB=5, DATA=10, ECC=18, DONE=19, ERR=20.
REQ-021 SHALL, when in IDLE and start=1, latch page_row into addr_row, clear corr_cnt and page_status, and go to BADCHK; a start received in any other state SHALL be ignored.
REQ-022 SHALL hold en_read=1 in every state from BADCHK through ECC, and 0 otherwise.
REQ-023 SHALL, in BADCHK, wait for addr_row_error to be nonzero: 1 goes to CMD_START, 2 goes to ERR with page_status=3.
REQ-024 SHALL spend exactly 1 cycle in CMD_START, 5 cycles in ADDR (a 3-bit cycle counter), and 1 cycle in CMD_FIN.
REQ-025 SHALL, in WAIT_RB, wait TWB_CYCLES cycles, then wait for the 2-flop-synchronized flash_rb to be 1, then go to DATA with read_data_cnt=0 and tRead=0.
REQ-026 SHALL spend 2 cycles per byte in DATA: tRead=0, then tRead=1; read_data_cnt SHALL increment on the tRead=1 cycle.
REQ-027 SHALL transfer 8384 bytes per page (8192 data plus 192 spare/ECC); read_data_cnt[13]=1 marks the spare bytes.
REQ-028 SHALL, on the tRead=1 cycle with read_data_cnt=8383, go to ECC with tRead=0, and hold read_data_cnt at 8383 while in ECC.
REQ-029 SHALL, in ECC, whenever ecc_state=2, increment corr_cnt (saturating at 127) and raise page_status to at least 1.
REQ-030 SHALL, in ECC, whenever ecc_state=3, set page_status to 2; 2 is sticky for the page.
REQ-031 SHALL, in ECC, go to DONE on the cycle ecc_success=1.
REQ-032 SHALL, if ecc_state and ecc_success arrive in the same cycle, count that ecc_state before the page completes.
REQ-033 SHALL, in DONE or ERR, pulse done=1 for one cycle and then return to IDLE.
REQ-034 SHALL hold busy=1 in every state except IDLE.
REQ-035 SHALL hold page_status and corr_cnt stable until the next accepted start.

Reset
REQ-036 SHALL, on rst=1 at any time including mid-page, immediately force: state=IDLE; en_read, tRead, busy and done to 0; read_data_cnt, addr_row, page_status and corr_cnt to 0; synchronizer flops to 0.
REQ-037 SHALL, after rst is released, accept a start only on a subsequent clock edge.

Configuration
REQ-038 SHALL, when READ_TIMEOUT_EN is defined, include a 17-bit counter in WAIT_RB; if flash_rb is not seen high within RB_TIMEOUT cycles, the block goes to ERR with page_status=3.
REQ-039 SHALL, when READ_TIMEOUT_EN is undefined, omit the counter, and WAIT_RB waits indefinitely.

Verification
REQ-040 SHALL verify a good page: start with page_row=0x000080, addr_row_error=1, flash_rb high after 20 cycles, ecc_state=1 for all 64 chunks -> state sequence 1,2,3x5,4,5,10,18,19; 8384 tRead rising edges; done pulse; page_status=0; corr_cnt=0.
REQ-041 SHALL verify a bad block: addr_row_error=2 in BADCHK -> state 20, done pulse, page_status=3, no CMD_START state and no tRead activity.
REQ-042 SHALL verify ECC accumulation: ecc_state=2 on 3 chunks and ecc_state=3 on 1 chunk -> page_status=2, corr_cnt=3.
REQ-043 SHALL verify the timeout, with READ_TIMEOUT_EN defined and RB_TIMEOUT=100: flash_rb held low -> state 20 about 100 cycles after TWB_CYCLES, page_status=3.
REQ-044 SHALL verify reset mid-page: rst asserted at read_data_cnt=4000 -> state, read_data_cnt and en_read all 0 asynchronously; a subsequent start completes normally.
REQ-045 SHALL verify the busy and boundary cases: start pulsed during DATA -> ignored, addr_row unchanged; read_data_cnt[13] rises exactly at byte 8192.
